// File: rtl/kb_event_fifo.sv
// rtl/kb_event_fifo.sv - PS/2 set-2 scan-code folder and key-event FIFO for the Get_KB_in syscall
// Optional macro KB_BREAK_EVENTS_EN: queue key-release (break) events with brk = 1.
module kb_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [7:0]        ScanCode,
  input  logic              ScanValid,
  input  logic              Get_KB_in,
  output logic [31:0]       KbData,
  output logic              KbEmpty,
  output logic              KbFull,
  output logic              KbOverflow,
  output logic [ADDR_W:0]   KbCount
);

`ifdef KB_BREAK_EVENTS_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  state_t            state, state_n;
  logic              push, push_ext;
`ifdef KB_BREAK_EVENTS_EN
  logic              push_brk;
`endif
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              is_prefix, is_error;
  logic              do_pop, do_push;

  assign is_error  = (ScanCode == 8'h00) || (ScanCode == 8'hFF);
  assign is_prefix = (ScanCode == 8'hE0) || (ScanCode == 8'hF0);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    push_ext = 1'b0;
`ifdef KB_BREAK_EVENTS_EN
    push_brk = 1'b0;
`endif
    if (ScanValid) begin
      if (is_error) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ScanCode == 8'hE0)      state_n = EXT;
            else if (ScanCode == 8'hF0) state_n = BRK;
            else                        push = 1'b1;
          end
          EXT: begin
            if (ScanCode == 8'hF0)      state_n = EXTBRK;
            else if (ScanCode == 8'hE0) state_n = EXT;
            else begin
              push     = 1'b1;
              push_ext = 1'b1;
              state_n  = IDLE;
            end
          end
          BRK, EXTBRK: begin
            // Release code byte is always consumed; it is only queued when break events are enabled.
            state_n = IDLE;
`ifdef KB_BREAK_EVENTS_EN
            if (!is_prefix) begin
              push     = 1'b1;
              push_brk = 1'b1;
              push_ext = (state == EXTBRK);
            end
`endif
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

`ifdef KB_BREAK_EVENTS_EN
  assign push_entry = {push_brk, push_ext, ScanCode};
`else
  assign push_entry = {push_ext, ScanCode};
`endif

  assign do_pop  = Get_KB_in && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: KbData is masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (do_push && !Reset) mem[wr_ptr] <= push_entry;
  end

  assign KbCount    = count;
  assign KbEmpty    = (count == '0);
  assign KbFull     = (count == FULL_CNT);
  assign KbOverflow = overflow;
  assign KbData     = KbEmpty ? 32'd0 : {{(32-EW){1'b0}}, mem[rd_ptr]};

endmodule

// File: tb/tb_kb_event_fifo.sv
// tb/tb_kb_event_fifo.sv - directed self-checking bench for kb_event_fifo
module tb_kb_event_fifo;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  ScanCode;
  logic        ScanValid;
  logic        Get_KB_in;
  logic [31:0] KbData;
  logic        KbEmpty, KbFull, KbOverflow;
  logic [3:0]  KbCount;

  int tests = 0;
  int fails = 0;

  kb_event_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .CLK(CLK), .Reset(Reset), .ScanCode(ScanCode), .ScanValid(ScanValid),
    .Get_KB_in(Get_KB_in), .KbData(KbData), .KbEmpty(KbEmpty), .KbFull(KbFull),
    .KbOverflow(KbOverflow), .KbCount(KbCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ScanValid = 1'b1;
    ScanCode  = b;
    @(negedge CLK);
    ScanValid = 1'b0;
    ScanCode  = 8'h00;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    Get_KB_in = 1'b1;
    #1 check(tag, KbData, exp);
    @(negedge CLK);
    Get_KB_in = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ScanCode = 8'h00; ScanValid = 1'b0; Get_KB_in = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    // 1: reset state, pop while empty
    check("rst_data", KbData, 32'd0);
    check("rst_empty", {31'd0, KbEmpty}, 32'd1);
    check("rst_full", {31'd0, KbFull}, 32'd0);
    check("rst_ovf", {31'd0, KbOverflow}, 32'd0);
    check("rst_count", {28'd0, KbCount}, 32'd0);
    pop_check("empty_pop_data", 32'd0);
    check("empty_pop_count", {28'd0, KbCount}, 32'd0);
    check("empty_pop_empty", {31'd0, KbEmpty}, 32'd1);

    // 2: single make code
    send(8'h1D);
    check("make_1d_data", KbData, 32'h0000001D);
    check("make_1d_count", {28'd0, KbCount}, 32'd1);
    pop_check("make_1d_pop", 32'h0000001D);
    check("after_pop_data", KbData, 32'd0);
    check("after_pop_empty", {31'd0, KbEmpty}, 32'd1);

    // 3: extended make, extended break
    send(8'hE0); send(8'h75);
    check("ext_make_data", KbData, 32'h00000175);
    send(8'hE0); send(8'hF0); send(8'h75);
`ifdef KB_BREAK_EVENTS_EN
    check("ext_brk_count", {28'd0, KbCount}, 32'd2);
    pop_check("ext_make_pop", 32'h00000175);
    pop_check("ext_brk_pop", 32'h00000375);
`else
    check("ext_brk_count", {28'd0, KbCount}, 32'd1);
    pop_check("ext_make_pop", 32'h00000175);
`endif
    check("t3_empty", {31'd0, KbEmpty}, 32'd1);

    // 4: overflow on ninth push, then in-order drain
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("fill_full", {31'd0, KbFull}, 32'd1);
    check("fill_count", {28'd0, KbCount}, 32'd8);
    check("fill_ovf", {31'd0, KbOverflow}, 32'd1);
    check("fill_head", KbData, 32'h00000001);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("drain_%0d", i), 32'(i));
    check("drain_empty", {31'd0, KbEmpty}, 32'd1);
    check("ovf_sticky", {31'd0, KbOverflow}, 32'd1);

    // 5: simultaneous push and pop while full
    pulse_reset();
    check("rst2_ovf", {31'd0, KbOverflow}, 32'd0);
    for (int i = 1; i <= 8; i++) send(8'(8'h10 + i));
    check("refill_full", {31'd0, KbFull}, 32'd1);
    ScanValid = 1'b1; ScanCode = 8'h2A; Get_KB_in = 1'b1;
    #1 check("pushpop_head", KbData, 32'h00000011);
    @(negedge CLK);
    ScanValid = 1'b0; ScanCode = 8'h00; Get_KB_in = 1'b0;
    check("pushpop_count", {28'd0, KbCount}, 32'd8);
    check("pushpop_ovf", {31'd0, KbOverflow}, 32'd0);
    for (int i = 2; i <= 8; i++) pop_check($sformatf("pp_drain_%0d", i), 32'(8'h10 + i));
    pop_check("pp_drain_2a", 32'h0000002A);
    check("pp_empty", {31'd0, KbEmpty}, 32'd1);

    // 6: reset drops partial prefix; error byte returns to IDLE
    send(8'hE0);
    pulse_reset();
    send(8'h1C);
    check("rst_prefix_data", KbData, 32'h0000001C);
    pop_check("rst_prefix_pop", 32'h0000001C);
    send(8'hF0); send(8'h00); send(8'h1C);
    check("err_byte_data", KbData, 32'h0000001C);
    check("err_byte_count", {28'd0, KbCount}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
